usrt_tx: RTL and testbench



---
 rtl/usrt_pkg.sv | 42 ++++
 rtl/usrt_tx_if.sv | 17 +
 rtl/usrt_bit_timer.sv | 31 +++
 rtl/usrt_tx.sv | 107 ++++++++++
 tb/tb_usrt_tx.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/usrt_pkg.sv
// Shared USRT definitions: parity encodings, tx FSM states, divisor width and
// standard baud divisors. Also imported by the status register.
package usrt_pkg;

  localparam int BAUD_W = 14;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Bit-period divisors for the supported line rates
  localparam logic [BAUD_W-1:0] DIV_1200   = 14'd8333;
  localparam logic [BAUD_W-1:0] DIV_2400   = 14'd4166;
  localparam logic [BAUD_W-1:0] DIV_4800   = 14'd2083;
  localparam logic [BAUD_W-1:0] DIV_9600   = 14'd1041;
  localparam logic [BAUD_W-1:0] DIV_19200  = 14'd520;
  localparam logic [BAUD_W-1:0] DIV_38400  = 14'd260;
  localparam logic [BAUD_W-1:0] DIV_57600  = 14'd173;
  localparam logic [BAUD_W-1:0] DIV_115200 = 14'd87;

  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  function automatic logic par_bit(input logic [7:0] data, input logic [1:0] mode);
    return (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

  // A one-cycle bit period would collapse the timer, so two is the floor
  function automatic logic [BAUD_W-1:0] clamp_baud(input logic [BAUD_W-1:0] baud);
    return (baud < BAUD_W'(2)) ? BAUD_W'(2) : baud;
  endfunction

endpackage

// File: rtl/usrt_tx_if.sv
// Request/line bundle between the Tx data register and the transmitter.
interface usrt_tx_if;
  import usrt_pkg::*;

  logic                i_Start;
  logic [7:0]          i_Data;
  logic [1:0]          i_Parity;
  logic [BAUD_W-1:0]   i_Baud;
  logic                o_Tx;
  logic                o_Busy;
  logic                o_Done;

  modport master (output i_Start, i_Data, i_Parity, i_Baud,
                  input  o_Tx, o_Busy, o_Done);
  modport slave  (input  i_Start, i_Data, i_Parity, i_Baud,
                  output o_Tx, o_Busy, o_Done);
endinterface

// File: rtl/usrt_bit_timer.sv
// Loadable bit-period counter: strikes on the last cycle of each bit period.
// Shared between transmitter and receiver.
module usrt_bit_timer #(
  parameter int BAUD_W = usrt_pkg::BAUD_W
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Restart,
  input  logic              i_En,
  input  logic [BAUD_W-1:0] i_Div,
  output logic              o_Strike
);

  logic [BAUD_W-1:0] r_Div;
  logic [BAUD_W-1:0] r_Cnt;

  assign o_Strike = i_En && (r_Cnt == (r_Div - BAUD_W'(1)));

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_Div <= '0;
      r_Cnt <= '0;
    end else if (i_Restart) begin
      r_Div <= i_Div;
      r_Cnt <= '0;
    end else if (i_En) begin
      r_Cnt <= o_Strike ? '0 : r_Cnt + BAUD_W'(1);
    end
  end

endmodule

// File: rtl/usrt_tx.sv
// USRT transmitter: start bit, 8 data bits LSB first, optional parity, one stop
// bit. Divisor and parity mode are frozen at the accepted start.
module usrt_tx
  import usrt_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BAUD_W = usrt_pkg::BAUD_W
) (
  input  logic       i_Pclk,
  input  logic       i_Reset,
  usrt_tx_if.slave   bus
);

  tx_state_e         r_State;
  logic [DATA_W-1:0] r_Shift;
  logic [2:0]        r_BitIdx;
  logic [1:0]        r_Par;
  logic              r_ParBit;
  logic              r_Tx;
  logic              r_Busy;
  logic              r_Done;
  logic              w_Accept;
  logic              w_Strike;

  assign w_Accept = (r_State == ST_IDLE) && bus.i_Start;

  usrt_bit_timer #(.BAUD_W(BAUD_W)) u_timer (
    .i_Clk     (i_Pclk),
    .i_Reset   (i_Reset),
    .i_Restart (w_Accept),
    .i_En      (r_Busy),
    .i_Div     (clamp_baud(bus.i_Baud)),
    .o_Strike  (w_Strike)
  );

  // r_Tx is loaded with the next bit on the strike edge so the line changes
  // exactly at bit boundaries with no combinational path to the pad.
  always_ff @(posedge i_Pclk) begin
    if (i_Reset) begin
      r_State  <= ST_IDLE;
      r_Shift  <= '0;
      r_BitIdx <= '0;
      r_Par    <= PAR_NONE;
      r_ParBit <= 1'b0;
      r_Tx     <= 1'b1;
      r_Busy   <= 1'b0;
      r_Done   <= 1'b0;
    end else begin
      r_Done <= 1'b0;
      unique case (r_State)
        ST_IDLE: begin
          if (bus.i_Start) begin
            r_Shift  <= bus.i_Data;
            r_Par    <= bus.i_Parity;
            r_ParBit <= par_bit(bus.i_Data, bus.i_Parity);
            r_BitIdx <= '0;
            r_Tx     <= 1'b0;
            r_Busy   <= 1'b1;
            r_State  <= ST_START;
          end
        end
        ST_START: begin
          if (w_Strike) begin
            r_Tx    <= r_Shift[0];
            r_State <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_Strike) begin
            if (r_BitIdx == 3'(DATA_W - 1)) begin
              if (par_enabled(r_Par)) begin
                r_Tx    <= r_ParBit;
                r_State <= ST_PARITY;
              end else begin
                r_Tx    <= 1'b1;
                r_State <= ST_STOP;
              end
            end else begin
              r_Shift  <= {1'b0, r_Shift[DATA_W-1:1]};
              r_Tx     <= r_Shift[1];
              r_BitIdx <= r_BitIdx + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (w_Strike) begin
            r_Tx    <= 1'b1;
            r_State <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_Strike) begin
            r_Busy  <= 1'b0;
            r_Done  <= 1'b1;
            r_State <= ST_IDLE;
          end
        end
        default: r_State <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_Tx   = r_Tx;
  assign bus.o_Busy = r_Busy;
  assign bus.o_Done = r_Done;

endmodule

// File: tb/tb_usrt_tx.sv
// Directed bench for usrt_tx: table of frames with hand-computed line bits,
// plus hand-written back-to-back and mid-frame reset sequences.
module tb_usrt_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usrt_tx_if bus();

  usrt_tx #(.DATA_W(8), .BAUD_W(14)) dut (
    .i_Pclk  (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [13:0] baud;
    logic [1:0]  par;
    logic [7:0]  data;
    logic [10:0] exp;   // line bits, index 0 = start bit
    int          nb;
    int          bper;
    int          poke;  // cycle at which a stray start/baud change is injected, -1 none
  } vec_t;

  vec_t vecs[9];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Called at +#1 after the accept edge; returns at +#1 in the o_Done cycle.
  task automatic check_frame(input logic [10:0] exp, input int nb, input int bper,
                             input int poke, input string nm);
    int busy_cyc = 0;
    for (int b = 0; b < nb; b++) begin
      int match = 0;
      for (int c = 0; c < bper; c++) begin
        if (b * bper + c == poke) begin
          bus.i_Start  = 1'b1;
          bus.i_Data   = 8'hAA;
          bus.i_Baud   = 14'd3;
          bus.i_Parity = 2'b01;
        end else if (b * bper + c == poke + 1) begin
          bus.i_Start = 1'b0;
        end
        if (bus.o_Tx === exp[b] && bus.o_Done === 1'b0) match++;
        if (bus.o_Busy === 1'b1) busy_cyc++;
        @(posedge clk); #1;
      end
      chk($sformatf("%s bit%0d cycles", nm, b), match, bper);
    end
    chk({nm, " busy_len"}, busy_cyc, nb * bper);
    chk({nm, " done"}, bus.o_Done, 1);
    chk({nm, " busy_end"}, bus.o_Busy, 0);
    chk({nm, " gap_tx"}, bus.o_Tx, 1);
  endtask

  task automatic idle_step(input string nm);
    @(posedge clk); #1;
    chk({nm, " done_clr"}, bus.o_Done, 0);
    chk({nm, " idle_tx"}, bus.o_Tx, 1);
  endtask

  task automatic run(input vec_t v, input string nm);
    bus.i_Start  = 1'b1;
    bus.i_Data   = v.data;
    bus.i_Parity = v.par;
    bus.i_Baud   = v.baud;
    @(posedge clk); #1;
    bus.i_Start = 1'b0;
    chk({nm, " accept_busy"}, bus.o_Busy, 1);
    check_frame(v.exp, v.nb, v.bper, v.poke, nm);
    idle_step(nm);
  endtask

  initial begin
    vecs[0] = '{14'd87, 2'b00, 8'h55, {2'b11, 8'h55, 1'b0},        10, 87, -1};
    vecs[1] = '{14'd4,  2'b01, 8'h03, {1'b1, 1'b0, 8'h03, 1'b0},   11, 4,  -1};
    vecs[2] = '{14'd4,  2'b10, 8'h03, {1'b1, 1'b1, 8'h03, 1'b0},   11, 4,  -1};
    vecs[3] = '{14'd4,  2'b01, 8'h01, {1'b1, 1'b1, 8'h01, 1'b0},   11, 4,  -1};
    vecs[4] = '{14'd4,  2'b10, 8'h00, {1'b1, 1'b1, 8'h00, 1'b0},   11, 4,  -1};
    vecs[5] = '{14'd4,  2'b11, 8'hA5, {2'b11, 8'hA5, 1'b0},        10, 4,  -1};
    vecs[6] = '{14'd0,  2'b00, 8'h3C, {2'b11, 8'h3C, 1'b0},        10, 2,  -1};
    vecs[7] = '{14'd1,  2'b00, 8'hC3, {2'b11, 8'hC3, 1'b0},        10, 2,  5};
    vecs[8] = '{14'd4,  2'b00, 8'h0F, {2'b11, 8'h0F, 1'b0},        10, 4,  10};

    rst          = 1'b1;
    bus.i_Start  = 1'b0;
    bus.i_Data   = 8'h00;
    bus.i_Parity = 2'b00;
    bus.i_Baud   = 14'd4;
    repeat (3) @(posedge clk);
    #1;
    chk("reset tx", bus.o_Tx, 1);
    chk("reset busy", bus.o_Busy, 0);
    chk("reset done", bus.o_Done, 0);
    rst = 1'b0;
    idle_step("post_reset");

    for (int i = 0; i < 9; i++) run(vecs[i], $sformatf("v%0d", i));

    // Back-to-back: second start issued in the o_Done cycle
    bus.i_Start = 1'b1; bus.i_Data = 8'h0F; bus.i_Parity = 2'b00; bus.i_Baud = 14'd4;
    @(posedge clk); #1;
    bus.i_Start = 1'b0;
    check_frame({2'b11, 8'h0F, 1'b0}, 10, 4, -1, "b2b_a");
    bus.i_Start = 1'b1; bus.i_Data = 8'hF0;
    @(posedge clk); #1;
    bus.i_Start = 1'b0;
    chk("b2b_b start_tx", bus.o_Tx, 0);
    check_frame({2'b11, 8'hF0, 1'b0}, 10, 4, -1, "b2b_b");
    idle_step("b2b_b");

    // Reset during data bit 3, then reset colliding with start
    bus.i_Start = 1'b1; bus.i_Data = 8'h5A; bus.i_Parity = 2'b00; bus.i_Baud = 14'd4;
    @(posedge clk); #1;
    bus.i_Start = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    chk("rst_mid bit3_tx", bus.o_Tx, 1);
    chk("rst_mid busy_before", bus.o_Busy, 1);
    rst = 1'b1;
    bus.i_Start = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid tx", bus.o_Tx, 1);
    chk("rst_mid busy", bus.o_Busy, 0);
    chk("rst_mid done", bus.o_Done, 0);
    @(posedge clk); #1;
    chk("rst_start busy", bus.o_Busy, 0);
    rst = 1'b0;
    bus.i_Start = 1'b0;
    @(posedge clk); #1;
    chk("rst_start no_frame", bus.o_Busy, 0);
    run('{14'd4, 2'b00, 8'h5A, {2'b11, 8'h5A, 1'b0}, 10, 4, -1}, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
